// File: rtl/arb_requester.sv
// arb_requester: queues device jobs and drives one req/gnt port of the two-port arbiter.
// Define ARB_REQ_TIMEOUT_EN to abort jobs that wait TIMEOUT cycles in REQ without a grant.
module arb_requester #(
    parameter int LEN_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     job_valid,
    input  logic [LEN_W-1:0]         job_len,
    output logic                     job_ready,
    input  logic                     gnt,
    output logic                     req,
    output logic                     xfer_beat,
    output logic                     done,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [LEN_W-1:0] beat_cnt;
    logic [WW-1:0]    wait_cnt;
    logic             req_q, push, pop, qual, expire, abort;

    assign job_ready = count != (AW+1)'(DEPTH);
    assign push      = job_valid && job_ready;
    assign pop       = state == IDLE && count != '0;
    // The arbiter holds a stale grant while idle, so the first REQ cycle never qualifies.
    assign qual      = gnt && wait_cnt != '0;
    assign req       = req_q;
    assign pending   = count;
    assign xfer_beat = state == XFER && gnt;
    assign done      = state == RELEASE && !abort;
    assign timeout   = state == RELEASE && abort;

`ifdef ARB_REQ_TIMEOUT_EN
    assign expire = wait_cnt == WW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            abort <= 1'b0;
        else if (state == REQ)
            abort <= !qual && expire;
`else
    assign expire = 1'b0;
    assign abort  = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = count != '0 ? REQ : IDLE;
            REQ:     state_nxt = qual ? XFER : expire ? RELEASE : REQ;
            XFER:    state_nxt = gnt && beat_cnt == '0 ? RELEASE : XFER;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= job_len;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            req_q    <= state_nxt == REQ || state_nxt == XFER;
            wr_ptr   <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            beat_cnt <= pop ? mem[rd_ptr] : (xfer_beat && beat_cnt != '0) ? beat_cnt - 1'b1 : beat_cnt;
            wait_cnt <= state == IDLE ? '0 : (state == REQ && wait_cnt != '1) ? wait_cnt + 1'b1 : wait_cnt;
        end
endmodule
